// File: rtl/fu_result_stage.sv
// fu_result_stage: ALU result capture stage with a 2-entry FIFO toward
// write-back, the {V,C,N,Z} status register and a saturating overflow counter.
// Ports:
//   clk, rst                   clock, async active-high reset
//   in_valid/in_ready          upstream handshake
//   in_fout, in_overflow, in_carryout, in_negative, in_zero
//                              ALU result and flags
//   in_fs, in_dst, in_wen, in_setflags
//                              function select, tag, write enable, flag update
//   out_valid/out_ready        write-back handshake
//   out_data, out_dst, out_wen head entry
//   flags, flag_clr            status register {V,C,N,Z} and its sync clear
//   ovf_count                  saturating count of overflowing flag-setting ops
//   occupancy                  valid entries, 0..2
module fu_result_stage #(
    parameter int DATA_W = 32,
    parameter int DST_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_fout,
    input  logic              in_overflow,
    input  logic              in_carryout,
    input  logic              in_negative,
    input  logic              in_zero,
    input  logic [3:0]        in_fs,
    input  logic [DST_W-1:0]  in_dst,
    input  logic              in_wen,
    input  logic              in_setflags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DST_W-1:0]  out_dst,
    output logic              out_wen,
    output logic [3:0]        flags,
    input  logic              flag_clr,
    output logic [CNT_W-1:0]  ovf_count,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] data_q [2];
    logic [DST_W-1:0]  dst_q  [2];
    logic [1:0]        wen_q;

    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [3:0]        flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic push;
    logic pop;
    logic arith;

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign arith     = (in_fs >= 4'd1) && (in_fs <= 4'd6);

    // Head is masked to zero when empty so stale storage never leaks out.
    assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;
    assign out_dst   = out_valid ? dst_q[rd_ptr_q]  : '0;
    assign out_wen   = out_valid & wen_q[rd_ptr_q];

    assign flags     = flags_q;
    assign ovf_count = cnt_q;
    assign occupancy = occ_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // flag_clr zeroes the base; a flag-setting push then overwrites only
    // the bits it owns, so unwritten bits end up cleared.
    always_comb begin
        flags_d = flag_clr ? 4'b0000 : flags_q;
        if (push && in_setflags) begin
            if (arith) begin
                flags_d = {in_overflow, in_carryout, in_negative, in_zero};
            end else begin
                flags_d[1] = in_negative;
                flags_d[0] = in_zero;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && in_setflags && arith && in_overflow && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
            flags_q   <= 4'b0000;
            cnt_q     <= '0;
            wen_q     <= 2'b00;
            data_q[0] <= '0;
            data_q[1] <= '0;
            dst_q[0]  <= '0;
            dst_q[1]  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
            if (push) begin
                data_q[wr_ptr_q] <= in_fout;
                dst_q[wr_ptr_q]  <= in_dst;
                wen_q[wr_ptr_q]  <= in_wen;
            end
        end
    end

endmodule

// File: tb/tb_fu_result_stage.sv
// tb_fu_result_stage: directed table-driven bench for fu_result_stage,
// plus hand sequences for counter saturation and async reset.
module tb_fu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_fout;
    logic        in_overflow;
    logic        in_carryout;
    logic        in_negative;
    logic        in_zero;
    logic [3:0]  in_fs;
    logic [4:0]  in_dst;
    logic        in_wen;
    logic        in_setflags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_dst;
    logic        out_wen;
    logic [3:0]  flags;
    logic        flag_clr;
    logic [7:0]  ovf_count;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fu_result_stage #(.DATA_W(32), .DST_W(5), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fout    (in_fout),
        .in_overflow(in_overflow),
        .in_carryout(in_carryout),
        .in_negative(in_negative),
        .in_zero    (in_zero),
        .in_fs      (in_fs),
        .in_dst     (in_dst),
        .in_wen     (in_wen),
        .in_setflags(in_setflags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dst    (out_dst),
        .out_wen    (out_wen),
        .flags      (flags),
        .flag_clr   (flag_clr),
        .ovf_count  (ovf_count),
        .occupancy  (occupancy)
    );

    typedef struct {
        logic        v;
        logic [31:0] fout;
        logic [3:0]  fs;
        logic [3:0]  vcnz;
        logic        sf;
        logic [4:0]  dst;
        logic        wen;
        logic        clr;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_data;
        logic [4:0]  e_dst;
        logic        e_wen;
        logic [1:0]  e_occ;
        logic [3:0]  e_flg;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        in_valid    = t.v;
        in_fout     = t.fout;
        in_fs       = t.fs;
        in_overflow = t.vcnz[3];
        in_carryout = t.vcnz[2];
        in_negative = t.vcnz[1];
        in_zero     = t.vcnz[0];
        in_setflags = t.sf;
        in_dst      = t.dst;
        in_wen      = t.wen;
        flag_clr    = t.clr;
        out_ready   = t.ordy;
    endtask

    task automatic check_all(input string tag, input vec_t t);
        check({tag, ".in_ready"},  32'(in_ready),  32'(t.e_ir));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(t.e_ov));
        check({tag, ".out_data"},  out_data,       t.e_data);
        check({tag, ".out_dst"},   32'(out_dst),   32'(t.e_dst));
        check({tag, ".out_wen"},   32'(out_wen),   32'(t.e_wen));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(t.e_occ));
        check({tag, ".flags"},     32'(flags),     32'(t.e_flg));
        check({tag, ".ovf_count"}, 32'(ovf_count), 32'(t.e_cnt));
    endtask

    vec_t p;

    initial begin
        // fields: v fout fs vcnz sf dst wen clr ordy |
        //         e_ir e_ov e_data e_dst e_wen e_occ e_flg e_cnt
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 4'b0000, 0};
        vecs[1]  = '{1, 32'h7FFFFFFF, 4'h2, 4'b1010, 1, 3, 1, 0, 1,
                     1, 0, 0, 0, 0, 0, 4'b0000, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,
                     1, 1, 32'h7FFFFFFF, 3, 1, 1, 4'b1010, 1};
        vecs[3]  = '{1, 32'hA, 4'h8, 4'b0000, 0, 1, 1, 0, 0,
                     1, 0, 0, 0, 0, 0, 4'b1010, 1};
        vecs[4]  = '{1, 32'hB, 4'h8, 4'b0000, 0, 2, 0, 0, 0,
                     1, 1, 32'hA, 1, 1, 1, 4'b1010, 1};
        vecs[5]  = '{1, 32'hC, 4'h3, 4'b0101, 1, 4, 1, 0, 0,
                     0, 1, 32'hA, 1, 1, 2, 4'b1010, 1};
        vecs[6]  = '{1, 32'hC, 4'h3, 4'b0101, 1, 4, 1, 0, 1,
                     0, 1, 32'hA, 1, 1, 2, 4'b1010, 1};
        vecs[7]  = '{1, 32'hC, 4'h3, 4'b0101, 1, 4, 1, 0, 1,
                     1, 1, 32'hB, 2, 0, 1, 4'b1010, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,
                     1, 1, 32'hC, 4, 1, 1, 4'b0101, 1};
        vecs[9]  = '{1, 32'hD, 4'h8, 4'b0000, 0, 5, 1, 0, 0,
                     1, 0, 0, 0, 0, 0, 4'b0101, 1};
        vecs[10] = '{1, 32'hE, 4'h8, 4'b0000, 0, 6, 1, 0, 1,
                     1, 1, 32'hD, 5, 1, 1, 4'b0101, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 1, 32'hE, 6, 1, 1, 4'b0101, 1};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,
                     1, 1, 32'hE, 6, 1, 1, 4'b0101, 1};
        vecs[13] = '{1, 32'h0, 4'h1, 4'b1111, 1, 0, 0, 0, 1,
                     1, 0, 0, 0, 0, 0, 4'b0101, 1};
        vecs[14] = '{1, 32'h55, 4'h8, 4'b1101, 1, 7, 1, 1, 1,
                     1, 1, 32'h0, 0, 0, 1, 4'b1111, 2};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1,
                     1, 1, 32'h55, 7, 1, 1, 4'b0001, 2};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,
                     1, 0, 0, 0, 0, 0, 4'b0000, 2};

        rst = 1'b1;
        drive(vecs[0]);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Overflowing arithmetic pushes; counter starts at 2 here.
        p = vecs[0];
        p.v = 1; p.fs = 4'h1; p.vcnz = 4'b1000; p.sf = 1;
        p.wen = 1; p.ordy = 1;
        for (int i = 0; i < 252; i++) begin
            @(negedge clk);
            p.fout = 32'(i + 100);
            p.dst  = 5'(i);
            drive(p);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("sat.mid", 32'(ovf_count), 32'd254);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(p);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("sat.cnt", 32'(ovf_count), 32'd255);
        check("sat.flags", 32'(flags), 32'b1000);

        // Drain, then fill to two entries with write-back stalled.
        @(negedge clk);
        out_ready = 1'b0;
        p.ordy = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            p.fout = 32'hF00 + 32'(i);
            p.dst  = 5'(20 + i);
            drive(p);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full.occ", 32'(occupancy), 32'd2);
        check("full.in_ready", 32'(in_ready), 32'd0);
        check("full.head", out_data, 32'hF00);
        check("full.cnt", 32'(ovf_count), 32'd255);

        // Reset asserted between clock edges must clear outputs at once.
        #2;
        rst = 1'b1;
        #1;
        check("arst.occ", 32'(occupancy), 32'd0);
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        check("arst.out_data", out_data, 32'd0);
        check("arst.out_dst", 32'(out_dst), 32'd0);
        check("arst.out_wen", 32'(out_wen), 32'd0);
        check("arst.flags", 32'(flags), 32'd0);
        check("arst.cnt", 32'(ovf_count), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post.occ", 32'(occupancy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
